// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the fetch sequencer and its wait timer.
package fetch_pkg;

    typedef enum logic [2:0] {
        RST_HOLD = 3'd0,
        REQ      = 3'd1,
        WAIT     = 3'd2,
        HOLD     = 3'd3,
        DRAIN    = 3'd4
    } fetch_state_t;

    localparam int unsigned DEFAULT_WIDTH      = 64;
    localparam int unsigned DEFAULT_RESET_HOLD = 2;
    localparam int unsigned DEFAULT_MAX_WAIT   = 64;

endpackage

// File: rtl/fetch_wait_timer.sv
// Response-wait counter: cleared on entry to a waiting state, counts cycles without a response.
// tc_o pulses on the increment that brings the count to MAX_WAIT-1.
module fetch_wait_timer #(
    parameter int unsigned MAX_WAIT = 64
) (
    input  logic clk,
    input  logic srst_i,
    input  logic clear_i,
    input  logic inc_i,
    output logic tc_o
);

    localparam int unsigned CW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);
    localparam logic [CW-1:0] PRE  = CW'(MAX_WAIT - 2);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Saturate at the terminal value so a long stall cannot wrap and re-fire.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != LAST)) begin
            count_d = count_q + 1'b1;
        end
    end

    assign tc_o = inc_i && !clear_i && (count_q == PRE);

    always_ff @(posedge clk) begin
        if (srst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: one imem request per PC, PC-flop enable, decode-stall buffering,
// and squashing of in-flight fetches on an execute or writeback redirect.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned RESET_HOLD = DEFAULT_RESET_HOLD,
    parameter int unsigned MAX_WAIT   = DEFAULT_MAX_WAIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_d,
    input  logic             branch_taken_e,
    input  logic             pc_src_w,
    input  logic             imem_ready,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             imem_req,
    output logic             enable_pc,
    output logic [WIDTH-1:0] instr_f,
    output logic             instr_valid_f,
    output logic             flush_d,
    output logic             timeout_err
);

    localparam int unsigned HW = (RESET_HOLD > 0) ? $clog2(RESET_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);

    fetch_state_t     state_q, state_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;

    logic             redirect;
    logic             deliver;
    logic [WIDTH-1:0] deliver_data;
    logic             req_c, en_c, flush_c;
    logic             waiting, timer_clear, timer_inc, timer_tc;

    assign redirect = branch_taken_e | pc_src_w;

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        buf_d        = buf_q;
        deliver      = 1'b0;
        deliver_data = buf_q;
        req_c        = 1'b0;
        en_c         = 1'b0;
        flush_c      = 1'b0;

        case (state_q)
            RST_HOLD: begin
                if (hold_q <= HOLD_ONE) state_d = REQ;
                if (hold_q != '0)       hold_d  = hold_q - 1'b1;
            end
            REQ: begin
                req_c = !redirect;
                if (redirect) begin
                    en_c    = 1'b1;
                    flush_c = 1'b1;
                end else if (imem_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    en_c    = 1'b1;
                    flush_c = 1'b1;
                    state_d = imem_rvalid ? REQ : DRAIN;
                end else if (imem_rvalid) begin
                    if (!stall_d) begin
                        deliver      = 1'b1;
                        deliver_data = imem_rdata;
                        state_d      = REQ;
                    end else begin
                        buf_d   = imem_rdata;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    en_c    = 1'b1;
                    flush_c = 1'b1;
                    state_d = REQ;
                end else if (!stall_d) begin
                    deliver = 1'b1;
                    state_d = REQ;
                end
            end
            DRAIN: begin
                // A further redirect only moves the PC; the stale response still has to be absorbed.
                if (redirect) begin
                    en_c    = 1'b1;
                    flush_c = 1'b1;
                end
                if (imem_rvalid) state_d = REQ;
            end
            default: state_d = RST_HOLD;
        endcase

        if (deliver) en_c = 1'b1;
    end

    assign instr_d   = deliver ? deliver_data : instr_q;
    assign valid_d   = deliver;
    assign timeout_d = timeout_q | timer_tc;

    assign waiting     = (state_q == WAIT) || (state_q == DRAIN);
    assign timer_clear = ((state_d == WAIT)  && (state_q != WAIT)) ||
                         ((state_d == DRAIN) && (state_q != DRAIN));
    assign timer_inc   = waiting && !imem_rvalid;

    fetch_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk     (clk),
        .srst_i  (reset),
        .clear_i (timer_clear),
        .inc_i   (timer_inc),
        .tc_o    (timer_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RST_HOLD;
            hold_q    <= HW'(RESET_HOLD);
            buf_q     <= '0;
            instr_q   <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            buf_q     <= buf_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    // Combinational controls are forced low while reset is asserted.
    assign imem_req      = req_c   && !reset;
    assign enable_pc     = en_c    && !reset;
    assign flush_d       = flush_c && !reset;
    assign instr_f       = instr_q;
    assign instr_valid_f = valid_q;
    assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer (RESET_HOLD=2, MAX_WAIT=4) with hand-computed expectations.
module tb_fetch_sequencer;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         stall_d = 1'b0;
    logic         branch_taken_e = 1'b0;
    logic         pc_src_w = 1'b0;
    logic         imem_ready = 1'b0;
    logic         imem_rvalid = 1'b0;
    logic [W-1:0] imem_rdata = '0;
    logic         imem_req;
    logic         enable_pc;
    logic [W-1:0] instr_f;
    logic         instr_valid_f;
    logic         flush_d;
    logic         timeout_err;

    int n_cmp = 0;
    int n_err = 0;

    fetch_sequencer #(
        .WIDTH      (W),
        .RESET_HOLD (2),
        .MAX_WAIT   (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall_d        (stall_d),
        .branch_taken_e (branch_taken_e),
        .pc_src_w       (pc_src_w),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .imem_req       (imem_req),
        .enable_pc      (enable_pc),
        .instr_f        (instr_f),
        .instr_valid_f  (instr_valid_f),
        .flush_d        (flush_d),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset: all outputs low, redirect ignored.
        tick(); tick();
        branch_taken_e = 1'b1; #1;
        chk("rst_req",   imem_req,      0);
        chk("rst_en",    enable_pc,     0);
        chk("rst_flush", flush_d,       0);
        chk("rst_valid", instr_valid_f, 0);
        chk("rst_instr", instr_f,       0);
        chk("rst_tmo",   timeout_err,   0);
        reset = 1'b0;
        // Hold cycle 1: redirect ignored in RST_HOLD.
        #1;
        chk("hold1_req",   imem_req,  0);
        chk("hold1_en",    enable_pc, 0);
        chk("hold1_flush", flush_d,   0);
        tick();
        branch_taken_e = 1'b0; #1;
        chk("hold2_req", imem_req, 0);
        tick();
        #1;
        chk("cyc3_req", imem_req, 1);

        // Basic fetch with one wait cycle, no stall.
        imem_ready = 1'b1; #1;
        chk("t2_req", imem_req, 1);
        tick();
        imem_ready = 1'b0; #1;
        chk("t2_wait_req", imem_req,  0);
        chk("t2_wait_en",  enable_pc, 0);
        tick();
        imem_rvalid = 1'b1; imem_rdata = 64'hA5; #1;
        chk("t2_deliver_en",    enable_pc, 1);
        chk("t2_deliver_flush", flush_d,   0);
        tick();
        imem_rvalid = 1'b0; imem_rdata = '0; #1;
        chk("t2_instr", instr_f,       64'hA5);
        chk("t2_valid", instr_valid_f, 1);
        chk("t2_req2",  imem_req,      1);
        chk("t2_en0",   enable_pc,     0);
        tick();
        #1;
        chk("t2_valid_drop", instr_valid_f, 0);
        chk("t2_instr_hold", instr_f,       64'hA5);

        // Response during decode stall: buffered, delivered on stall release.
        imem_ready = 1'b1; tick();
        imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 64'h3C; stall_d = 1'b1; #1;
        chk("t3_stall0_en", enable_pc, 0);
        tick();
        imem_rvalid = 1'b0; imem_rdata = 64'hFF; #1;
        chk("t3_stall1_en",    enable_pc,     0);
        chk("t3_stall1_valid", instr_valid_f, 0);
        tick();
        #1;
        chk("t3_stall2_en",  enable_pc, 0);
        chk("t3_stall2_req", imem_req,  0);
        tick();
        stall_d = 1'b0; #1;
        chk("t3_release_en", enable_pc, 1);
        tick();
        #1;
        chk("t3_instr", instr_f,       64'h3C);
        chk("t3_valid", instr_valid_f, 1);

        // Redirect in WAIT without response: drain the stale response.
        imem_ready = 1'b1; tick();
        imem_ready = 1'b0; branch_taken_e = 1'b1; #1;
        chk("t4_redir_en",    enable_pc, 1);
        chk("t4_redir_flush", flush_d,   1);
        chk("t4_redir_req",   imem_req,  0);
        tick();
        branch_taken_e = 1'b0; #1;
        chk("t4_drain_valid", instr_valid_f, 0);
        chk("t4_drain_req",   imem_req,      0);
        chk("t4_drain_en",    enable_pc,     0);
        tick();
        imem_rvalid = 1'b1; imem_rdata = 64'h11; #1;
        chk("t4_stale_en",  enable_pc, 0);
        chk("t4_stale_req", imem_req,  0);
        tick();
        imem_rvalid = 1'b0; imem_rdata = '0; #1;
        chk("t4_after_valid", instr_valid_f, 0);
        chk("t4_after_instr", instr_f,       64'h3C);
        chk("t4_after_req",   imem_req,      1);

        // Writeback redirect coincident with imem_ready in REQ: no accept.
        pc_src_w = 1'b1; imem_ready = 1'b1; #1;
        chk("t5_req",   imem_req,  0);
        chk("t5_en",    enable_pc, 1);
        chk("t5_flush", flush_d,   1);
        tick();
        pc_src_w = 1'b0; imem_ready = 1'b0; #1;
        chk("t5_still_req", imem_req, 1);
        tick();
        #1;
        chk("t5_no_accept", imem_req, 1);

        // Both redirects with a would-be deliver: redirect wins.
        imem_ready = 1'b1; tick();
        imem_ready = 1'b0; branch_taken_e = 1'b1; pc_src_w = 1'b1;
        imem_rvalid = 1'b1; imem_rdata = 64'h77; #1;
        chk("both_en",    enable_pc, 1);
        chk("both_flush", flush_d,   1);
        tick();
        branch_taken_e = 1'b0; pc_src_w = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; #1;
        chk("both_valid", instr_valid_f, 0);
        chk("both_instr", instr_f,       64'h3C);
        chk("both_req",   imem_req,      1);

        // Timeout: three wait cycles with no response sets the sticky flag.
        imem_ready = 1'b1; tick();
        imem_ready = 1'b0; #1;
        chk("t6_w1_tmo", timeout_err, 0);
        tick(); #1;
        chk("t6_w2_tmo", timeout_err, 0);
        tick(); #1;
        chk("t6_w3_tmo", timeout_err, 0);
        tick(); #1;
        chk("t6_w4_tmo", timeout_err, 1);
        imem_rvalid = 1'b1; imem_rdata = 64'h99; #1;
        chk("t6_late_en", enable_pc, 1);
        tick();
        imem_rvalid = 1'b0; imem_rdata = '0; #1;
        chk("t6_late_tmo",   timeout_err,   1);
        chk("t6_late_instr", instr_f,       64'h99);
        chk("t6_late_valid", instr_valid_f, 1);
        tick(); #1;
        chk("t6_sticky", timeout_err, 1);

        // Reset mid-operation clears everything; a late response is ignored.
        imem_ready = 1'b1; tick();
        imem_ready = 1'b0; reset = 1'b1; tick();
        reset = 1'b0; imem_rvalid = 1'b1; imem_rdata = 64'h55; #1;
        chk("rst2_tmo",   timeout_err,   0);
        chk("rst2_instr", instr_f,       0);
        chk("rst2_valid", instr_valid_f, 0);
        chk("rst2_en",    enable_pc,     0);
        chk("rst2_req",   imem_req,      0);
        tick();
        imem_rvalid = 1'b0; #1;
        chk("rst2_ignored_valid", instr_valid_f, 0);
        tick(); #1;
        chk("rst2_req_again", imem_req, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
